// File: rtl/mips_cpu_harvard_data_ram.sv
// mips_cpu_harvard_data_ram
// Word-addressed data RAM that answers the Harvard data port of mips_cpu_harvard.
// Writes complete in one cycle. Reads hold the core frozen through clk_enable
// for READ_LATENCY cycles, then present the word in the READY cycle.
// With READ_LATENCY == 0 the read is combinational and never stalls.
// Optional feature macro: MIPS_DATA_RAM_FAULT_EN. When it is defined, a sticky
// fault flag records out-of-window, misaligned and read+write-collision requests.
// When it is not defined, the fault port is tied low.
module mips_cpu_harvard_data_ram #(
    parameter int          ADDR_WIDTH   = 10,
    parameter logic [31:0] BASE_ADDR    = 32'h00001000,
    parameter int          READ_LATENCY = 2,
    parameter string       INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        clk_enable,
    output logic        fault
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int TAG_LSB = ADDR_WIDTH + 2;
    // The counter only has to hold READ_LATENCY-2.
    localparam int CNT_W   = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [ADDR_WIDTH-1:0]   lat_index;
    logic                    lat_hit;

    logic [31:0]             mem [DEPTH];

    logic                    hit;
    logic [ADDR_WIDTH-1:0]   index;
    logic                    misaligned;
    logic                    read_req;
    logic                    wr_en;

    // The window occupies one aligned block. Addresses outside it miss and never alias into it.
    assign hit        = (data_address[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign index      = data_address[TAG_LSB-1:2];
    assign misaligned = (data_address[1:0] != 2'b00);
    // A simultaneous write takes priority, so the request is treated as a plain non-stalling write.
    assign read_req   = data_read && !data_write;

    // Writes are accepted only while idle and unfrozen. Because clk_enable is low in reset, a reset also blocks writes.
    assign wr_en = (state == IDLE) && data_write && clk_enable && hit && !misaligned;

    // Read-stall sequencer: IDLE -> (WAIT x READ_LATENCY-1) -> READY -> IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_index <= '0;
            lat_hit   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_req && (READ_LATENCY > 0)) begin
                        lat_index <= index;
                        lat_hit   <= hit;
                        if (READ_LATENCY == 1) begin
                            state <= READY;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_W'(READ_LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= READY;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                READY: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall control: the core freezes in the same cycle that a read is requested, and it stays frozen throughout reset.
    always_comb begin
        clk_enable = 1'b0;
        if (reset_n) begin
            case (state)
                IDLE:    clk_enable = !(read_req && (READ_LATENCY > 0));
                WAIT:    clk_enable = 1'b0;
                READY:   clk_enable = 1'b1;
                default: clk_enable = 1'b0;
            endcase
        end
    end

    // Read data is driven only when the core consumes it. It is zero at every other time and for misses.
    always_comb begin
        data_readdata = '0;
        if (READ_LATENCY == 0) begin
            if (reset_n && data_read && hit) begin
                data_readdata = mem[index];
            end
        end else if ((state == READY) && lat_hit) begin
            data_readdata = mem[lat_index];
        end
    end

    // RAM write port. The array itself has no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[index] <= data_writedata;
        end
    end

`ifdef MIPS_DATA_RAM_FAULT_EN
    // Sticky access-error flag. It is raised by any bad request seen while idle, and only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault <= 1'b0;
        end else if ((state == IDLE) && (data_read || data_write) &&
                     (!hit || misaligned || (data_read && data_write))) begin
            fault <= 1'b1;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_mips_cpu_harvard_data_ram.sv
// Testbench for mips_cpu_harvard_data_ram.
// Three instances share the data-port stimulus: READ_LATENCY 0, 2 and 4.
// Each read pushes its expected word to a scoreboard queue. The entry is popped when the addressed instance releases clk_enable.
module tb_mips_cpu_harvard_data_ram;

`ifdef MIPS_DATA_RAM_FAULT_EN
    localparam logic FE = 1'b1;
`else
    localparam logic FE = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata [3];
    logic        cen   [3];
    logic        flt   [3];

    int          checks;
    int          failures;
    logic [31:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mips_cpu_harvard_data_ram #(.READ_LATENCY(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .data_address(addr), .data_read(rd),
        .data_write(wr), .data_writedata(wdata), .data_readdata(rdata[0]),
        .clk_enable(cen[0]), .fault(flt[0]));

    mips_cpu_harvard_data_ram #(.READ_LATENCY(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .data_address(addr), .data_read(rd),
        .data_write(wr), .data_writedata(wdata), .data_readdata(rdata[1]),
        .clk_enable(cen[1]), .fault(flt[1]));

    mips_cpu_harvard_data_ram #(.READ_LATENCY(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .data_address(addr), .data_read(rd),
        .data_write(wr), .data_writedata(wdata), .data_readdata(rdata[2]),
        .clk_enable(cen[2]), .fault(flt[2]));

    // All tasks start and end at 1 time unit after a rising edge. Outputs are sampled on the falling edge.

    task automatic do_reset();
        rd = 1'b0; wr = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        checks++;
        if (cen[1] !== 1'b1) begin
            failures++;
            $display("FAIL write_nostall addr=%h clk_enable=%b required=1", a, cen[1]);
        end
        @(posedge clk); #1 wr = 1'b0;
    endtask

    task automatic read_word(input int k, input int lat, input logic [31:0] a, input logic [31:0] expv);
        int          stalls;
        bit          done;
        logic [31:0] e;
        stalls = 0; done = 0;
        addr = a; rd = 1'b1;
        exp_q.push_back(expv);
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            if (cen[k] === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (rdata[k] !== e) begin
                    failures++;
                    $display("FAIL read_data dut=%0d addr=%h got=%h required=%h", k, a, rdata[k], e);
                end
                checks++;
                if (stalls != lat) begin
                    failures++;
                    $display("FAIL read_stalls dut=%0d addr=%h got=%0d required=%0d", k, a, stalls, lat);
                end
                done = 1;
            end else begin
                stalls++;
                checks++;
                if (rdata[k] !== 32'h0) begin
                    failures++;
                    $display("FAIL stall_data dut=%0d got=%h required=0", k, rdata[k]);
                end
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL read_timeout dut=%0d addr=%h got=no_ready required=ready", k, a);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        rd = 1'b0;
        @(negedge clk);
        checks++;
        if (rdata[k] !== 32'h0 || cen[k] !== 1'b1) begin
            failures++;
            $display("FAIL read_after_idle dut=%0d got=%h/%b required=0/1", k, rdata[k], cen[k]);
        end
        @(posedge clk); #1;
        // Let the slower instances finish any read they picked up from the shared bus.
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic check_fault(input string nm, input logic req);
        @(negedge clk);
        checks++;
        if (flt[1] !== req) begin
            failures++;
            $display("FAIL %s fault got=%b required=%b", nm, flt[1], req);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
        reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (cen[k] !== 1'b0 || rdata[k] !== 32'h0 || flt[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_hold dut=%0d got=%b/%h/%b required=0/0/0", k, cen[k], rdata[k], flt[k]);
                end
            end
        end
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cen[k] !== 1'b1 || rdata[k] !== 32'h0 || flt[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_release dut=%0d got=%b/%h/%b required=1/0/0", k, cen[k], rdata[k], flt[k]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        write_word(32'h0000_1000, 32'h0BAD_F00D);
        write_word(32'h0000_1004, 32'hDEAD_BEEF);
        write_word(32'h0000_1008, 32'hCAFE_0002);
        read_word(0, 0, 32'h0000_1004, 32'hDEAD_BEEF);
        read_word(0, 0, 32'h0000_1000, 32'h0BAD_F00D);
    endtask

    task automatic test_read_latency();
        read_word(1, 2, 32'h0000_1004, 32'hDEAD_BEEF);
        read_word(1, 2, 32'h0000_1008, 32'hCAFE_0002);
        check_fault("clean_reads", 1'b0);
    endtask

    task automatic test_out_of_range();
        read_word(1, 2, 32'h0000_0FFC, 32'h0);
        check_fault("oor_read", FE);
        write_word(32'h0000_2000, 32'h1111_1111);
        read_word(0, 0, 32'h0000_2000, 32'h0);
        read_word(0, 0, 32'h0000_1000, 32'h0BAD_F00D);
        write_word(32'h0000_1FFC, 32'hA5A5_5A5A);
        read_word(1, 2, 32'h0000_1FFC, 32'hA5A5_5A5A);
        check_fault("oor_sticky", FE);
        do_reset();
        check_fault("oor_cleared", 1'b0);
    endtask

    task automatic test_misaligned();
        write_word(32'h0000_1006, 32'h5555_5555);
        check_fault("misaligned_write", FE);
        read_word(0, 0, 32'h0000_1004, 32'hDEAD_BEEF);
        read_word(1, 2, 32'h0000_1007, 32'hDEAD_BEEF);
        do_reset();
    endtask

    task automatic test_collision();
        addr = 32'h0000_1008; wdata = 32'h1234_5678; rd = 1'b1; wr = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cen[k] !== 1'b1) begin
                failures++;
                $display("FAIL collision_nostall dut=%0d got=%b required=1", k, cen[k]);
            end
        end
        @(posedge clk); #1 rd = 1'b0; wr = 1'b0;
        check_fault("collision", FE);
        read_word(0, 0, 32'h0000_1008, 32'h1234_5678);
    endtask

    task automatic test_back_to_back();
        int stalls;
        int got;
        do_reset();
        stalls = 0; got = 0;
        addr = 32'h0000_1008; rd = 1'b1;
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'h1234_5678);
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk);
            if (cen[1] === 1'b1) begin
                checks++;
                if (rdata[1] !== exp_q.pop_front() || stalls != 2) begin
                    failures++;
                    $display("FAIL b2b_read n=%0d got=%h stalls=%0d required=12345678 stalls=2", got, rdata[1], stalls);
                end
                stalls = 0; got++;
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        rd = 1'b0;
        if (got < 2) begin
            checks++; failures++;
            $display("FAIL b2b_timeout got=%0d required=2", got);
            exp_q.delete();
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        addr = 32'h0000_1004; rd = 1'b1;
        @(negedge clk);
        checks++;
        if (cen[2] !== 1'b0) begin
            failures++;
            $display("FAIL midwait_stall1 got=%b required=0", cen[2]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (cen[2] !== 1'b0) begin
            failures++;
            $display("FAIL midwait_stall2 got=%b required=0", cen[2]);
        end
        #1 reset_n = 1'b0; rd = 1'b0;
        wr = 1'b1; wdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (cen[2] !== 1'b0 || rdata[2] !== 32'h0) begin
                failures++;
                $display("FAIL midwait_in_reset got=%b/%h required=0/0", cen[2], rdata[2]);
            end
            @(negedge clk);
        end
        @(posedge clk); #1 wr = 1'b0; reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (cen[2] !== 1'b1 || rdata[2] !== 32'h0) begin
                failures++;
                $display("FAIL midwait_released got=%b/%h required=1/0", cen[2], rdata[2]);
            end
            @(posedge clk); #1;
        end
        read_word(2, 4, 32'h0000_1004, 32'hDEAD_BEEF);
    endtask

    initial begin
        checks = 0; failures = 0;
        test_reset();
        test_write();
        test_read_latency();
        test_out_of_range();
        test_misaligned();
        test_collision();
        test_back_to_back();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
